stopwatch: RTL and testbench
============================

Name: stopwatch

Overview:
Elapsed-time measurement block. It is the measuring counterpart of the countdown game timer: it does not run for a preset length, it measures the time between a start event and a stop event. It runs on the 50 MHz system clock and reports elapsed time as total ticks and as seconds plus sub-second ticks. Game logic uses it for player reaction time and round-duration scoring.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
TICK_HZ, 1000, measurement resolution in ticks per second; CLK_HZ must be an exact multiple of TICK_HZ
MAX_TICKS, 32'hFFFFFFFF, saturation limit for the total tick count

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; zeroes all counts and begins measurement
stop  input  1  single-cycle pulse; freezes the measurement
clear  input  1  single-cycle pulse; returns to IDLE with all counts zero
running  output  1  high while measuring
done  output  1  one-cycle pulse when a measurement ends (stop or saturation)
overflow  output  1  sticky; high once the tick count has saturated at MAX_TICKS
ticks  output  32  total elapsed ticks
seconds  output  32  whole elapsed seconds
subsec  output  16  elapsed ticks within the current second, range 0..TICK_HZ-1

Behaviour:
- One clock domain; reset is asynchronous and active-low. All state is registered on the rising edge of clock.
- Reset drives: state=IDLE, running=0, done=0, overflow=0, ticks=0, seconds=0, subsec=0, prescaler=0.
- Reset applies immediately, including mid-measurement. No done pulse is produced on reset.
- DIV = CLK_HZ/TICK_HZ.
- Prescaler counts 0..DIV-1, only in RUNNING. When it equals DIV-1 it wraps to 0 and asserts an internal tick.
- On each tick:
  - ticks increments by 1.
  - subsec increments by 1.
  - When subsec = TICK_HZ-1, subsec wraps to 0 and seconds increments by 1 in the same cycle.
- States: IDLE, RUNNING, STOPPED, SATURATED.
- Command priority in a single cycle: clear > start > stop.
- clear (any state):
  - Next state is IDLE; all counts, the prescaler and overflow go to 0.
  - done is not pulsed.
- start (any state, clear low):
  - Next state is RUNNING; ticks, seconds, subsec, prescaler and overflow all go to 0.
  - A start while RUNNING restarts the measurement and does not pulse done.
- stop:
  - In RUNNING: next state is STOPPED; done=1 for exactly the next cycle.
  - If a tick occurs in the same cycle as stop, that tick is counted.
  - stop in IDLE, STOPPED or SATURATED is ignored.
- Saturation:
  - If a tick would take ticks to MAX_TICKS, ticks becomes MAX_TICKS and the next state is SATURATED.
  - overflow=1, done pulses once, and seconds/subsec hold their values from that same update.
  - SATURATED is left only by start, clear or reset.
- Latency:
  - start sampled in cycle N gives running=1 from cycle N+1.
  - The first tick makes ticks=1 at the edge ending cycle N+DIV.
  - stop sampled in cycle M gives running=0 and done=1 in cycle M+1, with counts already frozen.
- running=1 only in RUNNING.
- Outputs hold their values in STOPPED and SATURATED until the next start, clear or reset.
- Width rules:
  - All counters are unsigned.
  - The seconds counter wraps naturally at 2^32; it never wraps before ticks saturates at the default parameters.
  - subsec is zero-extended within its 16 bits, so TICK_HZ must be no greater than 65536.

Test Plan:
All scenarios use CLK_HZ=100, TICK_HZ=10, so DIV=10.
- Reset then idle: after reset_n is released, hold 100 cycles with no commands -> running=0, ticks=0, seconds=0, subsec=0, done never asserted.
- Basic measurement: start, then stop 125 cycles later -> next cycle running=0, done=1 for one cycle, ticks=12, seconds=1, subsec=2.
- Simultaneous commands:
  - start and stop in the same cycle -> a fresh RUNNING measurement, no done.
  - clear together with start -> IDLE, all counts 0.
- Restart and ignore:
  - start while RUNNING at ticks=7 -> ticks=0 the next cycle, no done.
  - stop in IDLE -> no state change.
- Saturation with MAX_TICKS=5: start and wait 60 cycles -> ticks=5, overflow=1, done pulsed exactly once, running=0; a later stop is ignored; a later start clears overflow.
- Asynchronous reset: assert reset_n=0 mid-cycle while RUNNING at ticks=3 -> all outputs 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/stopwatch.sv
// stopwatch
//   Measures the time between a start pulse and a stop pulse. A prescaler
//   divides the system clock down to the measurement resolution. Each
//   measurement tick advances a total tick count and a seconds/sub-second
//   pair. The total count saturates at MAX_TICKS, which ends the measurement.
//
// Ports
//   clock     in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   pulse: zero all counts and begin measuring
//   stop      in   pulse: freeze the measurement (only while running)
//   clear     in   pulse: return to idle with all counts zero
//   running   out  high while measuring
//   done      out  one-cycle pulse when a measurement ends (stop or saturation)
//   overflow  out  sticky flag, set when the tick count saturates
//   ticks     out  [31:0] total elapsed ticks
//   seconds   out  [31:0] whole elapsed seconds
//   subsec    out  [15:0] ticks within the current second, 0..TICK_HZ-1
module stopwatch #(
  parameter int          CLK_HZ    = 50000000,
  parameter int          TICK_HZ   = 1000,
  parameter logic [31:0] MAX_TICKS = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic        running,
  output logic        done,
  output logic        overflow,
  output logic [31:0] ticks,
  output logic [31:0] seconds,
  output logic [15:0] subsec
);

  localparam int              DIV        = CLK_HZ / TICK_HZ;
  localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST   = PW'(DIV - 1);
  localparam logic [15:0]     SUB_LAST   = 16'(TICK_HZ - 1);
  localparam logic [31:0]     TICKS_LAST = MAX_TICKS - 32'd1;

  typedef enum logic [1:0] {IDLE, RUNNING, STOPPED, SATURATED} state_t;

  state_t        state, state_next;
  logic [PW-1:0] prescaler, prescaler_next;
  logic [31:0]   ticks_next, seconds_next;
  logic [15:0]   subsec_next;
  logic          done_next, overflow_next;
  logic          tick;

  // State and counter registers. Everything, including the done pulse,
  // is registered so the outputs are glitch-free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      prescaler <= '0;
      ticks     <= '0;
      seconds   <= '0;
      subsec    <= '0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      prescaler <= prescaler_next;
      ticks     <= ticks_next;
      seconds   <= seconds_next;
      subsec    <= subsec_next;
      done      <= done_next;
      overflow  <= overflow_next;
    end
  end

  // Next-state and counter update. clear beats start beats stop. A tick in
  // the same cycle as stop is still counted. If that tick also reaches
  // MAX_TICKS the block saturates instead of stopping; both end the
  // measurement with a single done pulse.
  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    ticks_next     = ticks;
    seconds_next   = seconds;
    subsec_next    = subsec;
    done_next      = 1'b0;
    overflow_next  = overflow;
    tick           = (state == RUNNING) && (prescaler == PRE_LAST);

    if (clear) begin
      state_next     = IDLE;
      prescaler_next = '0;
      ticks_next     = '0;
      seconds_next   = '0;
      subsec_next    = '0;
      overflow_next  = 1'b0;
    end else if (start) begin
      state_next     = RUNNING;
      prescaler_next = '0;
      ticks_next     = '0;
      seconds_next   = '0;
      subsec_next    = '0;
      overflow_next  = 1'b0;
    end else if (state == RUNNING) begin
      prescaler_next = tick ? '0 : prescaler + PW'(1);
      if (tick) begin
        ticks_next = ticks + 32'd1;
        if (subsec == SUB_LAST) begin
          subsec_next  = '0;
          seconds_next = seconds + 32'd1;
        end else begin
          subsec_next = subsec + 16'd1;
        end
      end
      if (tick && (ticks == TICKS_LAST)) begin
        ticks_next    = MAX_TICKS;
        state_next    = SATURATED;
        overflow_next = 1'b1;
        done_next     = 1'b1;
      end else if (stop) begin
        state_next = STOPPED;
        done_next  = 1'b1;
      end
    end
  end

  assign running = (state == RUNNING);

endmodule

// File: tb/tb_stopwatch.sv
// tb_stopwatch
//   Drives two stopwatch instances from the same command inputs. Instance 0
//   uses the default saturation limit and instance 1 saturates at 5 ticks.
//   The reference model works only in elapsed clock cycles. Expected ticks
//   are cycles/DIV capped at the limit, and seconds/subsec follow from that
//   by division and remainder.
module tb_stopwatch;

  localparam int          CLK_HZ  = 100;
  localparam int          TICK_HZ = 10;
  localparam int          DIV     = CLK_HZ / TICK_HZ;
  localparam logic [31:0] SAT_MAX = 32'd5;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic        clear   = 1'b0;

  logic        running0, done0, overflow0;
  logic [31:0] ticks0, seconds0;
  logic [15:0] subsec0;
  logic        running1, done1, overflow1;
  logic [31:0] ticks1, seconds1;
  logic [15:0] subsec1;

  int testsRun    = 0;
  int testsFailed = 0;
  int doneCount0  = 0;
  int doneCount1  = 0;
  int doneBase;

  // Reference model state, one entry per instance
  bit     mRun[2];
  bit     mOvf[2];
  bit     mDone[2];
  longint mCycles[2];

  stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .running(running0), .done(done0), .overflow(overflow0),
    .ticks(ticks0), .seconds(seconds0), .subsec(subsec0)
  );

  stopwatch #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_TICKS(SAT_MAX)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .running(running1), .done(done1), .overflow(overflow1),
    .ticks(ticks1), .seconds(seconds1), .subsec(subsec1)
  );

  always #5 clock = ~clock;

  function automatic longint maxOf(input int i);
    return (i == 0) ? longint'(32'hFFFFFFFF) : longint'(SAT_MAX);
  endfunction

  function automatic longint expTicks(input int i);
    longint t;
    t = mCycles[i] / DIV;
    if (t > maxOf(i)) t = maxOf(i);
    return t;
  endfunction

  // Model update: a measurement is simply a count of clock edges spent
  // running. It ends on stop or when the derived tick count hits the limit.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mRun[i] = 1'b0; mOvf[i] = 1'b0; mDone[i] = 1'b0; mCycles[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        mDone[i] = 1'b0;
        if (clear) begin
          mRun[i] = 1'b0; mOvf[i] = 1'b0; mCycles[i] = 0;
        end else if (start) begin
          mRun[i] = 1'b1; mOvf[i] = 1'b0; mCycles[i] = 0;
        end else if (mRun[i]) begin
          mCycles[i]++;
          if (mCycles[i] / DIV >= maxOf(i)) begin
            mRun[i] = 1'b0; mOvf[i] = 1'b1; mDone[i] = 1'b1;
          end else if (stop) begin
            mRun[i] = 1'b0; mDone[i] = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkInstance(input int i, input logic r, input logic d,
                               input logic o, input logic [31:0] t,
                               input logic [31:0] s, input logic [15:0] ss);
    longint et;
    et = expTicks(i);
    checkOutput($sformatf("model_running%0d", i), 32'(r), 32'(mRun[i]));
    checkOutput($sformatf("model_done%0d", i), 32'(d), 32'(mDone[i]));
    checkOutput($sformatf("model_overflow%0d", i), 32'(o), 32'(mOvf[i]));
    checkOutput($sformatf("model_ticks%0d", i), t, 32'(et));
    checkOutput($sformatf("model_seconds%0d", i), s, 32'(et / TICK_HZ));
    checkOutput($sformatf("model_subsec%0d", i), 32'(ss), 32'(et % TICK_HZ));
  endtask

  task automatic checkAll();
    checkInstance(0, running0, done0, overflow0, ticks0, seconds0, subsec0);
    checkInstance(1, running1, done1, overflow1, ticks1, seconds1, subsec1);
    if (done0) doneCount0++;
    if (done1) doneCount1++;
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
    checkAll();
  endtask

  task automatic waitCycles(input int n);
    repeat (n) stepCycle();
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic c);
    start = s; stop = p; clear = c;
    stepCycle();
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  initial begin
    int r;

    // Reset, then idle for 100 cycles
    repeat (3) @(posedge clock);
    #1;
    checkAll();
    reset_n = 1'b1;
    doneBase = doneCount0;
    waitCycles(100);
    checkOutput("idle_running", 32'(running0), 32'd0);
    checkOutput("idle_ticks", ticks0, 32'd0);
    checkOutput("idle_seconds", seconds0, 32'd0);
    checkOutput("idle_subsec", 32'(subsec0), 32'd0);
    checkOutput("idle_done_count", 32'(doneCount0 - doneBase), 32'd0);

    // Basic measurement: stop sampled 125 cycles after start
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_running", 32'(running0), 32'd1);
    waitCycles(124);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("stop_running", 32'(running0), 32'd0);
    checkOutput("stop_done", 32'(done0), 32'd1);
    checkOutput("stop_ticks", ticks0, 32'd12);
    checkOutput("stop_seconds", seconds0, 32'd1);
    checkOutput("stop_subsec", 32'(subsec0), 32'd2);
    stepCycle();
    checkOutput("stop_done_once", 32'(done0), 32'd0);
    checkOutput("stop_hold_ticks", ticks0, 32'd12);

    // Simultaneous commands
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("startstop_running", 32'(running0), 32'd1);
    checkOutput("startstop_done", 32'(done0), 32'd0);
    checkOutput("startstop_ticks", ticks0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("clearstart_running", 32'(running0), 32'd0);
    checkOutput("clearstart_ticks", ticks0, 32'd0);

    // Restart while running at ticks=7
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(72);
    checkOutput("pre_restart_ticks", ticks0, 32'd7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("restart_ticks", ticks0, 32'd0);
    checkOutput("restart_done", 32'(done0), 32'd0);
    checkOutput("restart_running", 32'(running0), 32'd1);

    // stop in IDLE is ignored
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("idlestop_running", 32'(running0), 32'd0);
    checkOutput("idlestop_done", 32'(done0), 32'd0);
    checkOutput("idlestop_ticks", ticks0, 32'd0);

    // Saturation on the 5-tick instance
    doneBase = doneCount1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(60);
    checkOutput("sat_ticks", ticks1, 32'd5);
    checkOutput("sat_overflow", 32'(overflow1), 32'd1);
    checkOutput("sat_running", 32'(running1), 32'd0);
    checkOutput("sat_subsec", 32'(subsec1), 32'd5);
    checkOutput("sat_seconds", seconds1, 32'd0);
    checkOutput("sat_done_count", 32'(doneCount1 - doneBase), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("sat_stop_done", 32'(done1), 32'd0);
    checkOutput("sat_stop_overflow", 32'(overflow1), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("sat_restart_overflow", 32'(overflow1), 32'd0);
    checkOutput("sat_restart_running", 32'(running1), 32'd1);

    // Asynchronous reset mid-cycle at ticks=3
    waitCycles(30);
    checkOutput("pre_reset_ticks", ticks0, 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("areset_running", 32'(running0), 32'd0);
    checkOutput("areset_ticks", ticks0, 32'd0);
    checkOutput("areset_subsec", 32'(subsec0), 32'd0);
    checkOutput("areset_done", 32'(done0), 32'd0);
    checkOutput("areset_ticks1", ticks1, 32'd0);
    checkAll();
    waitCycles(2);
    reset_n = 1'b1;

    // Randomized command traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 99));
      applyStimulus(r < 4, (r >= 3) && (r < 8), r >= 98);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
